// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, opcode field
// position, the inactive opcode and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int IW_DEF = 39;
  localparam int AW_DEF = 8;

  localparam int OP_W   = 3;
  localparam int OP_MSB = IW_DEF - 1;
  localparam int OP_LSB = IW_DEF - OP_W;

  localparam logic [OP_W-1:0] OP_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [OP_W-1:0] get_opcode(input logic [IW_DEF-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: single outstanding req/ack transaction.
interface fetch_unit_if #(
  parameter int IW = fetch_unit_pkg::IW_DEF,
  parameter int AW = fetch_unit_pkg::AW_DEF
) ();

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: load has priority over increment; at the last program word
// it either wraps to zero (WRAP=1) or holds so the fetcher can stop there.
module pc_counter
  import fetch_unit_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int PROG_LEN = 256,
  parameter int WRAP     = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_addr,
  input  logic          i_inc,
  output logic [AW-1:0] o_pc,
  output logic          o_last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_LEN - 1);

  logic [AW-1:0] r_pc;
  logic          w_last;

  assign w_last = (r_pc == LAST_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      if (w_last) begin
        // Out-of-range targets never match LAST_ADDR and just count on.
        if (WRAP != 0) r_pc <= '0;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  assign o_pc   = r_pc;
  assign o_last = w_last;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake and instruction register.
//   state    | meaning
//   ST_IDLE  | not fetching; waits for start, jumps only reload the PC
//   ST_FETCH | read at PC outstanding (or one-cycle re-request bubble)
//   ST_HOLD  | instruction register valid, waiting for decode to accept
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int IW       = IW_DEF,
  parameter int AW       = AW_DEF,
  parameter int PROG_LEN = 256,
  parameter int WRAP     = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_stall,
  input  logic          i_jump,
  input  logic [AW-1:0] i_jump_addr,
  fetch_unit_if.master  mem_if,
  output logic [IW-1:0] o_instruction,
  output logic          o_instr_valid,
  output logic [AW-1:0] o_pc,
  output logic          o_busy,
  output logic          o_done
);

  fetch_state_t  r_state;
  logic          r_mem_req;
  logic [IW-1:0] r_instr;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_discard;
  logic [AW-1:0] r_jump_target;

  logic          w_ack;
  logic          w_pc_load;
  logic [AW-1:0] w_pc_load_addr;
  logic          w_pc_inc;
  logic [AW-1:0] w_pc;
  logic          w_last;
  logic          w_end;

  assign w_ack = r_mem_req && mem_if.mem_ack;
  assign w_end = (r_state == ST_HOLD) && !i_jump && !i_stall && w_last && (WRAP == 0);

  // A jump against an outstanding read is deferred until that read retires.
  always_comb begin
    w_pc_load      = 1'b0;
    w_pc_load_addr = i_jump_addr;
    w_pc_inc       = 1'b0;
    case (r_state)
      ST_IDLE:  w_pc_load = i_jump;
      ST_FETCH: begin
        if (!r_mem_req) begin
          w_pc_load = i_jump;
        end else if (w_ack) begin
          if (i_jump) begin
            w_pc_load = 1'b1;
          end else if (r_discard) begin
            w_pc_load      = 1'b1;
            w_pc_load_addr = r_jump_target;
          end
        end
      end
      ST_HOLD: begin
        if (i_jump)        w_pc_load = 1'b1;
        else if (!i_stall) w_pc_inc  = 1'b1;
      end
      default: ;
    endcase
  end

  pc_counter #(
    .AW       (AW),
    .PROG_LEN (PROG_LEN),
    .WRAP     (WRAP)
  ) u_pc_counter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_pc_load),
    .i_load_addr (w_pc_load_addr),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc),
    .o_last      (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_instr       <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_discard     <= 1'b0;
      r_jump_target <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_jump && i_start) begin
            r_state   <= ST_FETCH;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (mem_if.mem_ack) begin
            r_mem_req <= 1'b0;
            r_discard <= 1'b0;
            if (!i_jump && !r_discard) begin
              r_instr <= mem_if.mem_data;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end else if (i_jump) begin
            r_discard     <= 1'b1;
            r_jump_target <= i_jump_addr;
          end
        end
        ST_HOLD: begin
          if (i_jump || !i_stall) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            if (w_end) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_FETCH;
              r_mem_req <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_valid   <= 1'b0;
          r_instr   <= '0;
          r_busy    <= 1'b0;
          r_discard <= 1'b0;
        end
      endcase
    end
  end

  assign mem_if.mem_req  = r_mem_req;
  assign mem_if.mem_addr = w_pc;
  assign o_instruction   = r_instr;
  assign o_instr_valid   = r_valid;
  assign o_pc            = w_pc;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule
